// File: rtl/projectile_pkg.sv
// projectile_pkg: shared types and constants for the projectile scheduler.
//   proj_state_e : sweep FSM states (IDLE, MOVE, SPAWN_A, SPAWN_B)
//   proj_slot_t  : one pool slot {active, dir, x, y}
//   DIR_RIGHT / DIR_LEFT : slot direction encoding
//   make_shot()  : builds a freshly spawned, active slot record
package projectile_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    SPAWN_A = 2'd2,
    SPAWN_B = 2'd3
  } proj_state_e;

  typedef struct packed {
    logic       active;
    logic       dir;
    logic [9:0] x;
    logic [9:0] y;
  } proj_slot_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic proj_slot_t make_shot(input logic       dir,
                                           input logic [9:0] x,
                                           input logic [9:0] y);
    proj_slot_t s;
    s.active = 1'b1;
    s.dir    = dir;
    s.x      = x;
    s.y      = y;
    return s;
  endfunction

endpackage

// File: rtl/projectile_scheduler_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk   in  destination clock
//   rst_n in  synchronous active-low reset (clears all flops)
//   sig   in  asynchronous level input
//   rise  out one-cycle pulse on each synchronised 0->1 transition
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= sig;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/projectile_scheduler.sv
// projectile_scheduler: pool of projectile slots for the two-turret scene.
// On each frame tick the FSM walks the pool one slot per cycle (MOVE), then
// offers two spawn cycles (SPAWN_A, SPAWN_B) that place pending fire requests
// into the lowest free slot, with round-robin priority when both sides wait.
// Optional build macro: PROJ_BOUNCE_EN -- projectiles reflect off the screen
// edges instead of retiring.
// Ports:
//   vga_clk     in  sole clock
//   Reset       in  synchronous active-low reset
//   frame_clk   in  asynchronous frame strobe (synchronised internally)
//   fire_l_req  in  left turret fire key level
//   fire_r_req  in  right turret fire key level
//   fire_l_ack  out one-cycle pulse when a left shot is spawned
//   fire_r_ack  out one-cycle pulse when a right shot is spawned
//   slot_active out per-slot live flag
//   slot_dir    out per-slot direction (0 right, 1 left)
//   slot_x      out per-slot left edge, slot i at [i*10 +: 10]
//   slot_y      out per-slot top edge,  slot i at [i*10 +: 10]
//   busy        out high while the FSM is not in IDLE
module projectile_scheduler
  import projectile_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned PROJ_W    = 40,
  parameter int unsigned SPEED     = 1,
  parameter int unsigned L_SPAWN_X = 90,
  parameter int unsigned L_SPAWN_Y = 52,
  parameter int unsigned R_SPAWN_X = 510,
  parameter int unsigned R_SPAWN_Y = 430
) (
  input  logic                    vga_clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    fire_l_req,
  input  logic                    fire_r_req,
  output logic                    fire_l_ack,
  output logic                    fire_r_ack,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [NUM_SLOTS-1:0]    slot_dir,
  output logic [NUM_SLOTS*10-1:0] slot_x,
  output logic [NUM_SLOTS*10-1:0] slot_y,
  output logic                    busy
);

  localparam int unsigned    IDX_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
  localparam logic [10:0]    RIGHT_LIMIT = 11'(SCREEN_W - 1);
  localparam logic [10:0]    LOOKAHEAD   = 11'(PROJ_W + SPEED);
  localparam logic [9:0]     STEP        = 10'(SPEED);
  localparam logic [9:0]     RIGHT_CLAMP = 10'(SCREEN_W - 1 - PROJ_W);

  proj_state_e      state;
  logic [IDX_W-1:0] idx;
  proj_slot_t       slots [NUM_SLOTS];
  logic             pend_l, pend_r, rr;

  logic tick, edge_l, edge_r;

  sync_edge_detect u_frame_sync (
    .clk(vga_clk), .rst_n(Reset), .sig(frame_clk), .rise(tick)
  );
  sync_edge_detect u_fire_l_sync (
    .clk(vga_clk), .rst_n(Reset), .sig(fire_l_req), .rise(edge_l)
  );
  sync_edge_detect u_fire_r_sync (
    .clk(vga_clk), .rst_n(Reset), .sig(fire_r_req), .rise(edge_r)
  );

  // Next value of the slot under the sweep pointer.
  proj_slot_t  cur, nxt;
  logic [10:0] ahead;

  always_comb begin
    cur   = slots[idx];
    nxt   = cur;
    ahead = {1'b0, cur.x} + LOOKAHEAD;
    if (cur.active) begin
      if (cur.dir == DIR_RIGHT) begin
        if (ahead >= RIGHT_LIMIT) begin
`ifdef PROJ_BOUNCE_EN
          nxt.dir = DIR_LEFT;
          nxt.x   = RIGHT_CLAMP;
`else
          nxt.active = 1'b0;
`endif
        end else begin
          nxt.x = cur.x + STEP;
        end
      end else begin
        if (cur.x <= STEP) begin
`ifdef PROJ_BOUNCE_EN
          nxt.dir = DIR_RIGHT;
          nxt.x   = '0;
`else
          nxt.active = 1'b0;
`endif
        end else begin
          nxt.x = cur.x - STEP;
        end
      end
    end
  end

  // Spawn arbitration: lowest free slot, round-robin side when both wait.
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             both, pick_r, serve;
  proj_slot_t       shot;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!slots[i].active && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    both   = pend_l & pend_r;
    pick_r = both ? rr : pend_r;
    serve  = ((state == SPAWN_A) || (state == SPAWN_B)) &&
             (pend_l || pend_r) && free_found;
    shot   = pick_r ? make_shot(DIR_LEFT,  10'(R_SPAWN_X), 10'(R_SPAWN_Y))
                    : make_shot(DIR_RIGHT, 10'(L_SPAWN_X), 10'(L_SPAWN_Y));
  end

  always_ff @(posedge vga_clk) begin
    if (!Reset) begin
      state      <= IDLE;
      idx        <= '0;
      pend_l     <= 1'b0;
      pend_r     <= 1'b0;
      rr         <= 1'b0;
      fire_l_ack <= 1'b0;
      fire_r_ack <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      fire_l_ack <= serve & ~pick_r;
      fire_r_ack <= serve &  pick_r;
      // A fresh key edge wins over a same-cycle clear so it is never lost.
      pend_l <= (pend_l & ~(serve & ~pick_r)) | edge_l;
      pend_r <= (pend_r & ~(serve &  pick_r)) | edge_r;
      if (serve) begin
        slots[free_idx] <= shot;
        if (both) begin
          rr <= ~rr;
        end
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state <= MOVE;
            idx   <= '0;
          end
        end
        MOVE: begin
          slots[idx] <= nxt;
          if (idx == LAST_IDX) begin
            state <= SPAWN_A;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SPAWN_A: state <= SPAWN_B;
        SPAWN_B: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    slot_active = '0;
    slot_dir    = '0;
    slot_x      = '0;
    slot_y      = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_active[i]      = slots[i].active;
      slot_dir[i]         = slots[i].dir;
      slot_x[i*10 +: 10]  = slots[i].x;
      slot_y[i*10 +: 10]  = slots[i].y;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_projectile_scheduler.sv
// tb_projectile_scheduler: self-checking bench for projectile_scheduler.
// Directed frame table plus a slot model for long sequences; expected frame
// results are queued when stimulus is applied and compared after each sweep.
module tb_projectile_scheduler;

  localparam int NS = 4;
`ifdef PROJ_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b0;
  logic fire_l_req = 1'b0;
  logic fire_r_req = 1'b0;
  logic fire_l_ack, fire_r_ack, busy;
  logic [NS-1:0]    slot_active, slot_dir;
  logic [NS*10-1:0] slot_x, slot_y;

  projectile_scheduler #(.NUM_SLOTS(NS)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_clk(frame_clk),
    .fire_l_req(fire_l_req), .fire_r_req(fire_r_req),
    .fire_l_ack(fire_l_ack), .fire_r_ack(fire_r_ack),
    .slot_active(slot_active), .slot_dir(slot_dir),
    .slot_x(slot_x), .slot_y(slot_y), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          fr;
    int          kl;
    int          kr;
    logic [3:0]  act;
    logic [3:0]  dir;
    logic [39:0] x;
    logic [39:0] y;
  } vec_t;

  vec_t tbl [6];
  vec_t expq [$];

  // Reference slot model
  int mx [NS];
  int my [NS];
  bit ma [NS];
  bit md [NS];
  bit mpl, mpr, mrr;

  function automatic vec_t mkv(bit rst, bit fl, bit fr, int kl, int kr,
                               logic [3:0] act, logic [3:0] dir,
                               logic [39:0] x, logic [39:0] y);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fr = fr; v.kl = kl; v.kr = kr;
    v.act = act; v.dir = dir; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, got, want);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    frame_clk = 1'b0;
    fire_l_req = 1'b0;
    fire_r_req = 1'b0;
    repeat (3) @(negedge vga_clk);
    Reset = 1'b1;
    @(negedge vga_clk);
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 0; md[i] = 0;
    end
    mpl = 0; mpr = 0; mrr = 0;
  endtask

  task automatic fire(input bit l, input bit r);
    fire_l_req = l;
    fire_r_req = r;
    repeat (4) @(negedge vga_clk);
    fire_l_req = 1'b0;
    fire_r_req = 1'b0;
    repeat (4) @(negedge vga_clk);
    mpl = mpl | l;
    mpr = mpr | r;
  endtask

  task automatic model_frame();
    vec_t e;
    bit both, pr;
    int fi;
    e = mkv(0, 0, 0, -1, -1, '0, '0, '0, '0);
    for (int i = 0; i < NS; i++) begin
      if (ma[i]) begin
        if (!md[i]) begin
          if (mx[i] + 40 + 1 >= 639) begin
            if (BOUNCE) begin mx[i] = 599; md[i] = 1; end
            else ma[i] = 0;
          end else mx[i] = mx[i] + 1;
        end else begin
          if (mx[i] <= 1) begin
            if (BOUNCE) begin mx[i] = 0; md[i] = 0; end
            else ma[i] = 0;
          end else mx[i] = mx[i] - 1;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (mpl || mpr) begin
        both = mpl && mpr;
        pr = both ? mrr : mpr;
        fi = -1;
        for (int i = NS - 1; i >= 0; i--) if (!ma[i]) fi = i;
        if (fi >= 0) begin
          ma[fi] = 1; md[fi] = pr;
          mx[fi] = pr ? 510 : 90;
          my[fi] = pr ? 430 : 52;
          if (pr) begin e.kr = 5 + k; mpr = 0; end
          else begin e.kl = 5 + k; mpl = 0; end
          if (both) mrr = !mrr;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      e.act[i] = ma[i];
      e.dir[i] = md[i];
      e.x[i*10 +: 10] = 10'(mx[i]);
      e.y[i*10 +: 10] = 10'(my[i]);
    end
    expq.push_back(e);
  endtask

  // Raise frame_clk, trace acks/busy for 8 cycles from the first busy cycle,
  // then compare against the oldest queued expectation.
  task automatic run_frame(input string tag);
    vec_t e;
    bit seen;
    logic [7:0] lt, rt, bt, wl, wr;
    seen = 0; lt = '0; rt = '0; bt = '0;
    frame_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      if (busy) begin seen = 1; break; end
    end
    check({tag, " busy_start"}, 64'(seen), 64'd1);
    if (seen) begin
      for (int k = 0; k < 8; k++) begin
        lt[k] = fire_l_ack;
        rt[k] = fire_r_ack;
        bt[k] = busy;
        if (k < 7) @(negedge vga_clk);
      end
    end
    frame_clk = 1'b0;
    repeat (3) @(negedge vga_clk);
    if (expq.size() == 0) begin
      check({tag, " expq_empty"}, 64'd1, 64'd0);
    end else begin
      e = expq.pop_front();
      wl = (e.kl >= 0) ? (8'd1 << e.kl) : 8'd0;
      wr = (e.kr >= 0) ? (8'd1 << e.kr) : 8'd0;
      check({tag, " ack_l_trace"}, 64'(lt), 64'(wl));
      check({tag, " ack_r_trace"}, 64'(rt), 64'(wr));
      check({tag, " busy_trace"}, 64'(bt), 64'h3f);
      check({tag, " active"}, 64'(slot_active), 64'(e.act));
      check({tag, " dir"}, 64'(slot_dir), 64'(e.dir));
      check({tag, " x"}, 64'(slot_x), 64'(e.x));
      check({tag, " y"}, 64'(slot_y), 64'(e.y));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] at;
    bit seen;

    tbl[0] = mkv(1, 1, 0,  5, -1, 4'b0001, 4'b0000,
                 {10'd0, 10'd0, 10'd0, 10'd90}, {10'd0, 10'd0, 10'd0, 10'd52});
    tbl[1] = mkv(0, 0, 0, -1, -1, 4'b0001, 4'b0000,
                 {10'd0, 10'd0, 10'd0, 10'd91}, {10'd0, 10'd0, 10'd0, 10'd52});
    tbl[2] = mkv(1, 1, 1,  5,  6, 4'b0011, 4'b0010,
                 {10'd0, 10'd0, 10'd510, 10'd90}, {10'd0, 10'd0, 10'd430, 10'd52});
    tbl[3] = mkv(0, 1, 1,  6,  5, 4'b1111, 4'b0110,
                 {10'd90, 10'd510, 10'd509, 10'd91}, {10'd52, 10'd430, 10'd430, 10'd52});
    tbl[4] = mkv(0, 1, 0, -1, -1, 4'b1111, 4'b0110,
                 {10'd91, 10'd509, 10'd508, 10'd92}, {10'd52, 10'd430, 10'd430, 10'd52});
    tbl[5] = mkv(0, 0, 0, -1, -1, 4'b1111, 4'b0110,
                 {10'd92, 10'd508, 10'd507, 10'd93}, {10'd52, 10'd430, 10'd430, 10'd52});

    // Reset state
    do_reset();
    check("reset active", 64'(slot_active), 64'd0);
    check("reset acks", 64'({fire_l_ack, fire_r_ack}), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset xy", 64'({slot_x, slot_y}), 64'd0);

    // Directed frame table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].fl || tbl[i].fr) fire(tbl[i].fl, tbl[i].fr);
      expq.push_back(tbl[i]);
      run_frame($sformatf("tbl%0d", i));
    end

    // Held key fires once; a second edge while pending is absorbed
    do_reset();
    fire_l_req = 1'b1;
    repeat (4) @(negedge vga_clk);
    mpl = 1;
    model_frame(); run_frame("hold1");
    model_frame(); run_frame("hold2");
    fire_l_req = 1'b0;
    repeat (4) @(negedge vga_clk);
    fire(1, 0);
    fire(1, 0);
    model_frame(); run_frame("absorb1");
    model_frame(); run_frame("absorb2");

    // Fill the pool, keep a left request pending until a slot frees up,
    // and follow the right shot down to the left edge.
    do_reset();
    fire(1, 1); model_frame(); run_frame("fill1");
    fire(1, 1); model_frame(); run_frame("fill2");
    fire(1, 0);
    for (int f = 3; f <= 511; f++) begin
      model_frame();
      run_frame($sformatf("long%0d", f));
      if (f == 510) begin
        check("f510 slot1 x", 64'(slot_x[19:10]), 64'd1);
        if (BOUNCE) begin
          check("f510 slot0 x", 64'(slot_x[9:0]), 64'd599);
          check("f510 slot0 dir", 64'(slot_dir[0]), 64'd1);
        end else begin
          check("f510 slot0 x", 64'(slot_x[9:0]), 64'd90);
          check("f510 slot0 dir", 64'(slot_dir[0]), 64'd0);
        end
      end
      if (f == 511) begin
        if (BOUNCE) begin
          check("f511 slot1 active", 64'(slot_active[1]), 64'd1);
          check("f511 slot1 dir", 64'(slot_dir[1]), 64'd0);
          check("f511 slot1 x", 64'(slot_x[19:10]), 64'd0);
        end else begin
          check("f511 slot1 active", 64'(slot_active[1]), 64'd0);
        end
      end
    end

    // Reset in the middle of MOVE (slot index 2)
    do_reset();
    fire(1, 0); model_frame(); run_frame("prerst");
    fire(1, 0);
    frame_clk = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clk);
      if (busy) begin seen = 1; break; end
    end
    check("midrst busy_start", 64'(seen), 64'd1);
    repeat (2) @(negedge vga_clk);
    Reset = 1'b0;
    @(negedge vga_clk);
    check("midrst active", 64'(slot_active), 64'd0);
    check("midrst dir", 64'(slot_dir), 64'd0);
    check("midrst xy", 64'({slot_x, slot_y}), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    frame_clk = 1'b0;
    at = '0;
    for (int k = 0; k < 6; k++) begin
      at[k] = fire_l_ack | fire_r_ack;
      @(negedge vga_clk);
    end
    check("midrst acks", 64'(at), 64'd0);
    Reset = 1'b1;
    @(negedge vga_clk);
    for (int i = 0; i < NS; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 0; md[i] = 0;
    end
    mpl = 0; mpr = 0; mrr = 0;
    model_frame(); run_frame("postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
